// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection,
// branch/jump squash control and saturating perf counters.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [13:0]       id_ctrl,
  input  logic [1:0]        id_pcsrc,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm_ext,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [4:0]        id_shamt,
  input  logic              ex_branch_taken,
  input  logic              ext_stall,
  output logic              ex_valid,
  output logic [13:0]       ex_ctrl,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm_ext,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [4:0]        ex_shamt,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output logic [CNT_W-1:0]  bubble_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              r_valid;
  logic [13:0]       r_ctrl;
  logic [DATA_W-1:0] r_pc_plus4;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm_ext;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_rd;
  logic [4:0]        r_shamt;
  logic [CNT_W-1:0]  r_bub_cnt;
  logic [CNT_W-1:0]  r_fl_cnt;

  logic w_load_use;
  logic w_jump_id;
  logic w_hold;
  logic w_flush;
  logic w_bubble;
  logic w_load;
  logic w_bub_inc;

  assign w_load_use = r_valid & r_ctrl[4] & (r_rt != 5'd0) & id_valid
                    & ((r_rt == id_rs) | (r_rt == id_rt));
  assign w_jump_id  = id_valid & (id_pcsrc != 2'b00);

  assign w_hold  = ext_stall | (w_load_use & ~ex_branch_taken);
  // A jump waiting on a load-use hazard stalls before it squashes.
  assign w_flush = ex_branch_taken
                 | (w_jump_id & ~w_load_use & ~ext_stall);

  assign w_bubble  = ex_branch_taken | (~ext_stall & w_load_use);
  assign w_load    = ~ex_branch_taken & ~ext_stall & ~w_load_use;
  assign w_bub_inc = ~ex_branch_taken & ~ext_stall & w_load_use;

  always_ff @(posedge clk) begin
    if (reset || w_bubble) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_pc_plus4 <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm_ext  <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_shamt    <= '0;
    end else if (w_load) begin
      r_valid    <= id_valid;
      r_ctrl     <= id_ctrl;
      r_pc_plus4 <= id_pc_plus4;
      r_rs_data  <= id_rs_data;
      r_rt_data  <= id_rt_data;
      r_imm_ext  <= id_imm_ext;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_rd       <= id_rd;
      r_shamt    <= id_shamt;
    end
  end

  // The flush output itself is the count source: one per squash.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bub_cnt <= '0;
      r_fl_cnt  <= '0;
    end else begin
      if (w_bub_inc && r_bub_cnt != CNT_MAX)
        r_bub_cnt <= r_bub_cnt + CNT_ONE;
      if (w_flush && r_fl_cnt != CNT_MAX)
        r_fl_cnt <= r_fl_cnt + CNT_ONE;
    end
  end

  assign ex_valid     = r_valid;
  assign ex_ctrl      = r_ctrl;
  assign ex_pc_plus4  = r_pc_plus4;
  assign ex_rs_data   = r_rs_data;
  assign ex_rt_data   = r_rt_data;
  assign ex_imm_ext   = r_imm_ext;
  assign ex_rs        = r_rs;
  assign ex_rt        = r_rt;
  assign ex_rd        = r_rd;
  assign ex_shamt     = r_shamt;
  assign pc_hold      = w_hold;
  assign ifid_hold    = w_hold;
  assign ifid_flush   = w_flush;
  assign bubble_count = r_bub_cnt;
  assign flush_count  = r_fl_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: reference model plus directed
// hazard/squash scenarios and a short pseudo-random run.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic        v;
    logic [13:0] ctrl;
    logic [31:0] pc;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
  } bun_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [13:0]   id_ctrl;
  logic [1:0]    id_pcsrc;
  logic [DW-1:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext;
  logic [4:0]    id_rs, id_rt, id_rd, id_shamt;
  logic          ex_branch_taken, ext_stall;
  logic          ex_valid;
  logic [13:0]   ex_ctrl;
  logic [DW-1:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext;
  logic [4:0]    ex_rs, ex_rt, ex_rd, ex_shamt;
  logic          pc_hold, ifid_hold, ifid_flush;
  logic [CW-1:0] bubble_count, flush_count;

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pcsrc(id_pcsrc),
    .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_shamt(id_shamt),
    .ex_branch_taken(ex_branch_taken), .ext_stall(ext_stall),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_shamt(ex_shamt),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold),
    .ifid_flush(ifid_flush),
    .bubble_count(bubble_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit armed = 1'b0;
  int seq = 0;

  bun_t m_ex;
  int   m_bub, m_fl;
  bun_t in_b, dut_b;

  assign in_b  = {id_valid, id_ctrl, id_pc_plus4, id_rs_data,
                  id_rt_data, id_imm_ext, id_rs, id_rt, id_rd,
                  id_shamt};
  assign dut_b = {ex_valid, ex_ctrl, ex_pc_plus4, ex_rs_data,
                  ex_rt_data, ex_imm_ext, ex_rs, ex_rt, ex_rd,
                  ex_shamt};

  // Is the ID instruction reading a register the EX load will write?
  function automatic bit hazard(input bun_t e, input bun_t d);
    if (!(e.v && e.ctrl[4] && d.v)) return 1'b0;
    if (e.rt == 5'd0) return 1'b0;
    return (e.rt == d.rs) || (e.rt == d.rt);
  endfunction

  function automatic bit exp_hold();
    return ext_stall || (hazard(m_ex, in_b) && !ex_branch_taken);
  endfunction

  function automatic bit exp_flush();
    bit jmp;
    jmp = id_valid && (id_pcsrc != 2'b00);
    if (ex_branch_taken) return 1'b1;
    return jmp && !hazard(m_ex, in_b) && !ext_stall;
  endfunction

  always @(posedge clk) begin
    bit fl, lu;
    fl = exp_flush();
    lu = hazard(m_ex, in_b);
    if (reset) begin
      m_ex = '0; m_bub = 0; m_fl = 0;
    end else begin
      if (fl && m_fl < CMAX) m_fl = m_fl + 1;
      if (ex_branch_taken) m_ex = '0;
      else if (ext_stall) m_ex = m_ex;
      else if (lu) begin
        m_ex = '0;
        if (m_bub < CMAX) m_bub = m_bub + 1;
      end else m_ex = in_b;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      total++;
      if (dut_b !== m_ex) begin
        bad++;
        $display("FAIL ex_bundle act=%h exp=%h", dut_b, m_ex);
      end
      chk("m_pc_hold", 64'(pc_hold), 64'(exp_hold()));
      chk("m_ifid_hold", 64'(ifid_hold), 64'(exp_hold()));
      chk("m_ifid_flush", 64'(ifid_flush), 64'(exp_flush()));
      chk("m_bubble_count", 64'(bubble_count), 64'(m_bub));
      chk("m_flush_count", 64'(flush_count), 64'(m_fl));
    end
  end

  task automatic setid(input logic v, input logic [13:0] c,
                       input logic [1:0] pcs, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [31:0] rsd);
    id_valid    = v;
    id_ctrl     = c;
    id_pcsrc    = pcs;
    id_rs       = rs;
    id_rt       = rt;
    id_rd       = rt + 5'd1;
    id_shamt    = rs ^ rt;
    id_rs_data  = rsd;
    id_rt_data  = rsd ^ 32'h5a5a_0000;
    id_imm_ext  = {16'h0, rsd[15:0]} + 32'd7;
    id_pc_plus4 = 32'h400 + 32'(seq) * 4;
    seq++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    ex_branch_taken = 1'b0;
    ext_stall = 1'b0;
    setid(0, 14'h0, 2'b00, 5'd0, 5'd0, 32'h0);
    step();
    armed = 1'b1;
    step();
    reset = 1'b0;
    neg();
    chk("rst_valid", 64'(ex_valid), 0);
    chk("rst_bub", 64'(bubble_count), 0);
    chk("rst_flush", 64'(flush_count), 0);
    chk("rst_pc_hold", 64'(pc_hold), 0);
    #1;

    // basic load
    setid(1, 14'h0006, 2'b00, 5'd1, 5'd2, 32'h1234);
    step();
    neg();
    chk("basic_ctrl", 64'(ex_ctrl), 64'h0006);
    chk("basic_rsd", 64'(ex_rs_data), 64'h1234);
    chk("basic_valid", 64'(ex_valid), 1);
    chk("basic_hold", 64'(pc_hold), 0);
    #1;

    // load-use on rs
    setid(1, 14'h0012, 2'b00, 5'd3, 5'd8, 32'h100);
    step();
    setid(1, 14'h0006, 2'b00, 5'd8, 5'd9, 32'h200);
    neg();
    chk("lu_pc_hold", 64'(pc_hold), 1);
    chk("lu_ifid_hold", 64'(ifid_hold), 1);
    chk("lu_flush", 64'(ifid_flush), 0);
    step();
    neg();
    chk("lu_bub_valid", 64'(ex_valid), 0);
    chk("lu_bub_ctrl", 64'(ex_ctrl), 0);
    chk("lu_bub_cnt", 64'(bubble_count), 1);
    chk("lu_release", 64'(pc_hold), 0);
    step();
    neg();
    chk("lu_after_ctrl", 64'(ex_ctrl), 64'h0006);
    chk("lu_after_rs", 64'(ex_rs), 8);
    #1;

    // $0 target and non-load producer
    setid(1, 14'h0012, 2'b00, 5'd4, 5'd0, 32'h300);
    step();
    setid(1, 14'h0006, 2'b00, 5'd0, 5'd8, 32'h310);
    neg();
    chk("r0_no_stall", 64'(pc_hold), 0);
    step();
    setid(1, 14'h0006, 2'b00, 5'd8, 5'd5, 32'h320);
    neg();
    chk("noload_no_stall", 64'(pc_hold), 0);
    step();
    neg();
    chk("noload_bub", 64'(bubble_count), 1);
    #1;

    // branch beats stall and load-use
    setid(1, 14'h0012, 2'b00, 5'd1, 5'd8, 32'h400);
    step();
    setid(1, 14'h0006, 2'b00, 5'd8, 5'd2, 32'h410);
    ex_branch_taken = 1'b1;
    ext_stall = 1'b1;
    neg();
    chk("br_flush", 64'(ifid_flush), 1);
    chk("br_pc_hold", 64'(pc_hold), 1);
    step();
    ex_branch_taken = 1'b0;
    ext_stall = 1'b0;
    neg();
    chk("br_valid", 64'(ex_valid), 0);
    chk("br_fl_cnt", 64'(flush_count), 1);
    chk("br_bub_cnt", 64'(bubble_count), 1);
    #1;

    // jr after a load to $31
    setid(1, 14'h0012, 2'b00, 5'd2, 5'd31, 32'h500);
    step();
    setid(1, 14'h0000, 2'b10, 5'd31, 5'd0, 32'h510);
    neg();
    chk("jr_c1_hold", 64'(pc_hold), 1);
    chk("jr_c1_flush", 64'(ifid_flush), 0);
    step();
    neg();
    chk("jr_c2_hold", 64'(pc_hold), 0);
    chk("jr_c2_flush", 64'(ifid_flush), 1);
    step();
    neg();
    chk("jr_fl_cnt", 64'(flush_count), 2);
    chk("jr_bub_cnt", 64'(bubble_count), 2);
    #1;

    // two more load-use events saturate bubble_count
    setid(1, 14'h0012, 2'b00, 5'd1, 5'd7, 32'h600);
    step();
    setid(1, 14'h0006, 2'b00, 5'd7, 5'd0, 32'h610);
    step();
    step();
    setid(1, 14'h0012, 2'b00, 5'd1, 5'd7, 32'h620);
    step();
    setid(1, 14'h0006, 2'b00, 5'd0, 5'd7, 32'h630);
    step();
    neg();
    chk("sat_bub", 64'(bubble_count), 3);
    #1;

    // jumps saturate flush_count
    setid(1, 14'h0000, 2'b01, 5'd0, 5'd0, 32'h700);
    step();
    step();
    neg();
    chk("sat_fl", 64'(flush_count), 3);
    #1;

    // reset while a load-use stall is pending
    setid(1, 14'h0012, 2'b00, 5'd1, 5'd6, 32'h800);
    step();
    setid(1, 14'h0006, 2'b00, 5'd6, 5'd0, 32'h810);
    neg();
    chk("pre_rst_hold", 64'(pc_hold), 1);
    #1;
    reset = 1'b1;
    step();
    neg();
    chk("mrst_valid", 64'(ex_valid), 0);
    chk("mrst_rsd", 64'(ex_rs_data), 0);
    chk("mrst_bub", 64'(bubble_count), 0);
    chk("mrst_fl", 64'(flush_count), 0);
    chk("mrst_hold", 64'(pc_hold), 0);
    #1;
    reset = 1'b0;

    // pseudo-random traffic against the model
    for (int i = 0; i < 80; i++) begin
      setid(1'($urandom_range(0, 1)), 14'($urandom),
            ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2))
                                        : 2'b00,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom);
      ex_branch_taken = ($urandom_range(0, 6) == 0);
      ext_stall = ($urandom_range(0, 5) == 0);
      step();
    end
    ex_branch_taken = 1'b0;
    ext_stall = 1'b0;
    neg();
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
